// File: rtl/integral_image_gen.sv
`default_nettype none
// ============================================================================
// Module   : integral_image_gen
// Purpose  : Streaming integral-image generator for one detection window.
//            Accepts raster-order pixels of a WINDOW_WIDTH x WINDOW_HEIGHT
//            window and emits ii(x,y) with row / window end-of-transfer flags.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            din_valid/ready  - pixel input handshake, din_data = pixel
//            dout_valid/ready - integral output handshake, dout_data = ii(x,y)
//            dout_eot[0]      - last pixel of a row
//            dout_eot[1]      - last pixel of the window
// Config   : INTEGRAL_SATURATE_EN - saturate each addition at 2^W_DATA-1
//            (otherwise additions wrap modulo 2^W_DATA).
// Revision : 1.0 - initial release
// ============================================================================
module integral_image_gen #(
  parameter int W_PIX         = 8,
  parameter int W_DATA        = 18,
  parameter int WINDOW_WIDTH  = 24,
  parameter int WINDOW_HEIGHT = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [W_PIX-1:0]  din_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [W_DATA-1:0] dout_data,
  output logic [1:0]        dout_eot
);

  localparam int c_XW = (WINDOW_WIDTH  > 1) ? $clog2(WINDOW_WIDTH)  : 1;
  localparam int c_YW = (WINDOW_HEIGHT > 1) ? $clog2(WINDOW_HEIGHT) : 1;
  localparam logic [c_XW-1:0] c_X_LAST = c_XW'(WINDOW_WIDTH - 1);
  localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(WINDOW_HEIGHT - 1);

`ifdef INTEGRAL_SATURATE_EN
  function automatic logic [W_DATA-1:0] add_w(input logic [W_DATA-1:0] a,
                                              input logic [W_DATA-1:0] b);
    logic [W_DATA:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W_DATA] ? {W_DATA{1'b1}} : s[W_DATA-1:0];
  endfunction
`else
  function automatic logic [W_DATA-1:0] add_w(input logic [W_DATA-1:0] a,
                                              input logic [W_DATA-1:0] b);
    return a + b;
  endfunction
`endif

  logic [c_XW-1:0]   r_x;
  logic [c_YW-1:0]   r_y;
  logic [W_DATA-1:0] r_row_acc;
  logic [W_DATA-1:0] r_line [WINDOW_WIDTH];
  logic              r_valid;
  logic [W_DATA-1:0] r_data;
  logic [1:0]        r_eot;

  logic              w_accept;
  logic              w_x_last;
  logic              w_y_last;
  logic [W_DATA-1:0] w_pix;
  logic [W_DATA-1:0] w_line_rd;
  logic [W_DATA-1:0] w_row_sum;
  logic [W_DATA-1:0] w_ii;

  // Single output stage: can take a new pixel whenever the stage is empty or
  // is being drained in the same cycle.
  assign din_ready = !r_valid || dout_ready;
  assign w_accept  = din_valid && din_ready;
  assign w_x_last  = (r_x == c_X_LAST);
  assign w_y_last  = (r_y == c_Y_LAST);
  assign w_pix     = W_DATA'(din_data);

  always_comb begin
    // First row of a window ignores whatever the line buffer still holds
    // from the previous window (or from before reset).
    w_line_rd = (r_y == '0) ? '0 : r_line[r_x];
    w_row_sum = add_w(r_row_acc, w_pix);
    w_ii      = add_w(w_row_sum, w_line_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_row_acc <= '0;
    end else if (w_accept) begin
      if (w_x_last) begin
        r_x       <= '0;
        r_row_acc <= '0;
        r_y       <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x       <= r_x + 1'b1;
        r_row_acc <= w_row_sum;
      end
    end
  end

  // Line buffer has no reset; stale content is masked by the y == 0 select.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line[r_x] <= w_ii;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_eot   <= 2'b00;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_ii;
      r_eot   <= {w_x_last && w_y_last, w_x_last};
    end else if (dout_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign dout_valid = r_valid;
  assign dout_data  = r_data;
  assign dout_eot   = r_eot;

endmodule
`default_nettype wire

// File: doc/integral_image_gen.md
# integral_image_gen

Streaming integral-image generator for one detection window. It accepts raw pixels in raster order, one window of WINDOW_WIDTH×WINDOW_HEIGHT at a time, and emits the integral value ii(x,y) for each pixel. Each value is tagged with row and window end-of-transfer flags. It sits directly upstream of window_buffer: its dout_data/dout_eot feed window_buffer's din_data/din_eot.

## Interface
Parameters:
- W_PIX, 8, pixel width.
- W_DATA, 18, integral value width; the default holds 24·24·255 = 146880.
- WINDOW_WIDTH, 24, pixels per row.
- WINDOW_HEIGHT, 24, rows per window.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- din_valid  in  1  pixel valid.
- din_ready  out  1  pixel accepted when din_valid & din_ready.
- din_data  in  W_PIX  unsigned pixel.
- dout_valid  out  1  integral value valid.
- dout_ready  in  1  consumer ready.
- dout_data  out  W_DATA  ii(x,y).
- dout_eot  out  2  [0] last pixel of row (x = WINDOW_WIDTH-1); [1] last pixel of window (x = WINDOW_WIDTH-1 and y = WINDOW_HEIGHT-1).

## Operation
- Position counters:
  - x counts 0..WINDOW_WIDTH-1; y counts 0..WINDOW_HEIGHT-1.
  - Both advance only on an input handshake.
  - x wraps to 0 and increments y at end of row.
  - Both wrap to 0 after the last window pixel, so the next window starts at the next accepted pixel.
- Row accumulator row_acc:
  - Running sum of the current row, excluding the current pixel.
  - Cleared to 0 when accepting x = WINDOW_WIDTH-1.
- Line buffer line[0..WINDOW_WIDTH-1], W_DATA each:
  - Holds ii of the previous row.
  - Read before write at index x in the same cycle; no reset.
- On accept: ii = row_acc + din_data + (y == 0 ? 0 : line[x]).
  - line[x] ← ii; row_acc ← row_acc + din_data.
  - ii and eot flags go to the output register.
- The y == 0 mask makes each window independent of stale line-buffer content.
- Arithmetic is unsigned W_DATA-bit. Without the configuration macro, results wrap modulo 2^W_DATA.
- Output register:
  - Single stage: din_ready = !dout_valid | dout_ready.
  - Loads on accept; dout_valid is cleared when dout_ready is high and no new accept occurs.
  - While dout_valid & !dout_ready, dout_data and dout_eot are held stable.

## Timing
- Reset (async assert, deasserted synchronously by the system):
  - dout_valid = 0, dout_data = 0, dout_eot = 2'b00.
  - x = y = 0, row_acc = 0.
  - din_ready = 1 from the first cycle after reset.
- Latency: the value for an accepted pixel appears on dout the cycle after the input handshake.
- Throughput: 1 pixel/cycle with dout_ready held high.
- Simultaneous accept and output handshake in the same cycle: the register reloads; there is no bubble.
- Stall: din_ready drops combinationally when dout_valid & !dout_ready. No pixel is lost or duplicated.
- Reset mid-window: the partial window is discarded. The first pixel after reset is treated as x = 0, y = 0.
- Window boundary: there is no idle cycle between windows. The pixel after eot[1] starts the next window with y == 0 masking.
- dout_eot[1] is asserted only together with dout_eot[0].

## Configuration
- INTEGRAL_SATURATE_EN defined:
  - Each addition saturates at 2^W_DATA-1.
  - Saturated values are written to the line buffer and to the output.
- Not defined: plain modulo-2^W_DATA addition with no extra logic.
- With default parameters, results are identical either way.

## Test plan
- Constant pixel 1, one window, dout_ready = 1:
  - dout_data sequence equals (x+1)(y+1); final value 576.
  - dout_eot = 2'b01 at each x = 23 with y < 23; 2'b11 on the final value.
  - Exactly 576 outputs.
- Constant pixel 255:
  - ii(0,0) = 255, ii(23,0) = 6120; final value 146880 with no wrap.
- Random dout_ready (50%) with ramp pixel = (x+y) mod 256:
  - Output stream is identical to the dout_ready = 1 run.
  - dout_data is stable during every stall cycle.
- Two back-to-back windows (first all 200, second all 1):
  - Second window yields (x+1)(y+1) exactly, proving line-buffer masking.
  - There is no gap cycle between windows.
- Assert rst_n low for 1 cycle after 100 accepted pixels:
  - Immediately dout_valid = 0 and dout_data = 0.
  - Next window of all-1 pixels produces 1, 2, 3, … from x = y = 0.
- W_DATA = 16, all pixels 255:
  - With INTEGRAL_SATURATE_EN, the final value is 65535.
  - Without it, the final value is 146880 mod 65536 = 15808.
